// File: rtl/itr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default I/O port
// addresses and the source-ID width helper.
package itr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StBusy = 2'd2
    } state_e;

    localparam int unsigned MSKADD_DEF = 0;
    localparam int unsigned ACKADD_DEF = 1;
    localparam int unsigned IDADD_DEF  = 0;
    localparam int unsigned PNDADD_DEF = 1;

    // $clog2(n), held at a minimum of 1 so a vector is never zero-width.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/itr_ctrl_prio_enc.sv
// Combinational lowest-index-wins priority encoder; index 0 has highest priority.
module itr_ctrl_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: captures source rising edges, masks them, dispatches one
// interrupt at a time by fixed priority and waits for a software acknowledge.
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned NUBITS = 16,
    parameter int unsigned NBIOIN = 2,
    parameter int unsigned NBIOOU = 2,
    parameter int unsigned MSKADD = MSKADD_DEF,
    parameter int unsigned ACKADD = ACKADD_DEF,
    parameter int unsigned IDADD  = IDADD_DEF,
    parameter int unsigned PNDADD = PNDADD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NBIOOU-1:0] addr_out,
    input  logic              out_en,
    input  logic [NBIOIN-1:0] addr_in,
    input  logic              req_in,
    output logic [NUBITS-1:0] rd_data,
    output logic              rd_hit,
    output logic              itr,
    output logic              busy
);

    localparam int unsigned IDW = id_width(NSRC);
    localparam logic [NBIOOU-1:0] MSK_A = NBIOOU'(MSKADD);
    localparam logic [NBIOOU-1:0] ACK_A = NBIOOU'(ACKADD);
    localparam logic [NBIOIN-1:0] ID_A  = NBIOIN'(IDADD);
    localparam logic [NBIOIN-1:0] PND_A = NBIOIN'(PNDADD);

    state_e          state_q, state_d;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] ack_clr;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic            any;
    logic [IDW-1:0]  idx;
    logic            wr_msk, wr_ack;
    logic            unused_io;

    assign unused_io = ^io_out[NUBITS-1:NSRC];
    assign wr_msk    = out_en && (addr_out == MSK_A);
    assign wr_ack    = out_en && (addr_out == ACK_A);

    itr_ctrl_prio_enc #(
        .N  (NSRC),
        .IW (IDW)
    ) u_prio_enc (
        .req (pend_q & mask_q),
        .any (any),
        .idx (idx)
    );

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        ack_clr  = '0;
        itr      = 1'b0;
        busy     = 1'b0;
        case (state_q)
            StIdle: begin
                if (any) begin
                    cur_id_d = idx;
                    state_d  = StFire;
                end
            end
            StFire: begin
                itr     = 1'b1;
                busy    = 1'b1;
                state_d = StBusy;
            end
            StBusy: begin
                busy = 1'b1;
                if (wr_ack) begin
                    ack_clr[cur_id_q] = 1'b1;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new edge in the ack cycle must survive the clear, so set is applied last.
    assign pend_d = (pend_q & ~ack_clr) | (src & ~src_q);
    assign mask_d = wr_msk ? io_out[NSRC-1:0] : mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            src_q    <= src;
            pend_q   <= '0;
            mask_q   <= '0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            cur_id_q <= cur_id_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_in == ID_A) begin
            rd_data[NUBITS-1] = busy;
            rd_data[IDW-1:0]  = cur_id_q;
        end else if (addr_in == PND_A) begin
            rd_data[NSRC-1:0] = pend_q;
        end
    end

    assign rd_hit = req_in && ((addr_in == ID_A) || (addr_in == PND_A));

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed self-checking bench for itr_ctrl with default parameters.
module tb_itr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src;
    logic [15:0] io_out;
    logic [1:0]  addr_out;
    logic        out_en;
    logic [1:0]  addr_in;
    logic        req_in;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        itr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    itr_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .rd_data  (rd_data),
        .rd_hit   (rd_hit),
        .itr      (itr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d, output logic h);
        addr_in = a;
        req_in  = 1'b1;
        #1;
        d       = rd_data;
        h       = rd_hit;
        req_in  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        out_en   = 1'b1;
        addr_out = a;
        io_out   = d;
        tick();
        out_en   = 1'b0;
        io_out   = '0;
    endtask

    // Ticks n times; reports how many ticks saw itr high and the first such tick (1-based).
    task automatic run_count(input int n, output int hits, output int first);
        hits  = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (itr === 1'b1) begin
                hits++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        h;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL reset_itr: got %b expected 0", itr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000 || h !== 1'b1) begin
            errors++; $display("FAIL reset_pend: got %h/%b expected 0000/1", d, h);
        end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h0000 || h !== 1'b1) begin
            errors++; $display("FAIL reset_id: got %h/%b expected 0000/1", d, h);
        end
        rd(2'd2, d, h);
        checks++; if (d !== 16'h0000 || h !== 1'b0) begin
            errors++; $display("FAIL rd_other: got %h/%b expected 0000/0", d, h);
        end
        addr_in = 2'd0;
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rd_hit_noreq: got %b expected 0", rd_hit); end
    endtask

    task automatic test_masked_pending();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        wr(2'd0, 16'h0000);
        src = 4'b0100;
        tick();
        src = 4'b0000;
        run_count(6, hits, first);
        checks++; if (hits !== 0) begin errors++; $display("FAIL masked_itr: got %0d pulses expected 0", hits); end
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0004) begin errors++; $display("FAIL masked_pend: got %h expected 0004", d); end
    endtask

    task automatic test_dispatch();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        wr(2'd0, 16'h000F);
        run_count(5, hits, first);
        checks++; if (hits !== 1 || first !== 1) begin
            errors++; $display("FAIL dispatch_pulse: got %0d pulses first %0d expected 1/1", hits, first);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dispatch_busy: got %b expected 1", busy); end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8002) begin errors++; $display("FAIL dispatch_id: got %h expected 8002", d); end
        wr(2'd2, 16'h0000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL other_write_busy: got %b expected 1", busy); end
        wr(2'd1, 16'h0000);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_busy: got %b expected 0", busy); end
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ack_pend: got %h expected 0000", d); end
    endtask

    task automatic test_priority();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        src = 4'b1010;
        tick();
        src = 4'b0000;
        run_count(3, hits, first);
        checks++; if (hits !== 1 || first !== 1) begin
            errors++; $display("FAIL prio_first_pulse: got %0d/%0d expected 1/1", hits, first);
        end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8001) begin errors++; $display("FAIL prio_first_id: got %h expected 8001", d); end
        wr(2'd1, 16'h0000);
        checks++; if (itr !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got %b expected 0", itr); end
        run_count(3, hits, first);
        checks++; if (hits !== 1 || first !== 1) begin
            errors++; $display("FAIL prio_second_pulse: got %0d/%0d expected 1/1", hits, first);
        end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8003) begin errors++; $display("FAIL prio_second_id: got %h expected 8003", d); end
        wr(2'd1, 16'h0000);
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL prio_pend_clear: got %h expected 0000", d); end
    endtask

    task automatic test_ack_collision();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        src = 4'b0001;
        tick();
        src = 4'b0000;
        run_count(3, hits, first);
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL coll_id: got %h expected 8000", d); end
        src = 4'b0001;
        wr(2'd1, 16'h0000);
        src = 4'b0000;
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL coll_pend: got %h expected 0001", d); end
        run_count(3, hits, first);
        checks++; if (hits !== 1 || first !== 1) begin
            errors++; $display("FAIL coll_refire: got %0d/%0d expected 1/1", hits, first);
        end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8000) begin errors++; $display("FAIL coll_refire_id: got %h expected 8000", d); end
        wr(2'd1, 16'h0000);
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL coll_clear: got %h expected 0000", d); end
    endtask

    task automatic test_reset_held_src();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        src = 4'b0010;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr(2'd0, 16'h000F);
        run_count(4, hits, first);
        checks++; if (hits !== 0) begin errors++; $display("FAIL held_itr: got %0d pulses expected 0", hits); end
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL held_pend: got %h expected 0000", d); end
        src = 4'b0000;
        tick();
        src = 4'b0010;
        run_count(4, hits, first);
        checks++; if (hits !== 1 || first !== 2) begin
            errors++; $display("FAIL held_rearm: got %0d/%0d expected 1/2", hits, first);
        end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h8001) begin errors++; $display("FAIL held_id: got %h expected 8001", d); end
    endtask

    task automatic test_reset_busy();
        logic [15:0] d;
        logic        h;
        int          hits, first;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_pre_busy: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || itr !== 1'b0) begin
            errors++; $display("FAIL rb_outputs: got busy %b itr %b expected 0/0", busy, itr);
        end
        rd(2'd1, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rb_pend: got %h expected 0000", d); end
        rd(2'd0, d, h);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rb_id: got %h expected 0000", d); end
        run_count(4, hits, first);
        checks++; if (hits !== 0) begin errors++; $display("FAIL rb_no_itr: got %0d pulses expected 0", hits); end
    endtask

    initial begin
        rst      = 1'b1;
        src      = '0;
        io_out   = '0;
        addr_out = '0;
        out_en   = 1'b0;
        addr_in  = '0;
        req_in   = 1'b0;
        test_reset();
        test_masked_pending();
        test_dispatch();
        test_priority();
        test_ack_collision();
        test_reset_held_src();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
